// File: rtl/shift_pipe.sv
// ---------------------------------------------------------------------------
// shift_pipe
//
// Pipelined logarithmic barrel shifter with a valid/ready handshake on both
// sides. It serves the CORDIC datapath (x>>>i, y>>>i terms) and the
// normaliser. The shift is split into SHW mux levels, taken MSB-first
// (2^(SHW-1) down to 1). A register stage follows every PIPE_EVERY levels,
// which gives L = ceil(SHW/PIPE_EVERY) stages. The mode, remaining amount,
// operand sign and tag travel with the data through every stage.
//
// Parameters
//   WIDTH       data width, power of 2, >= 4
//   PIPE_EVERY  mux levels per register stage, 1..SHW
//   TAG_W       sideband tag width, >= 1
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset; clears every stage
//   in_valid    operation offered
//   in_ready    operation can be taken this cycle (combinational ready chain)
//   in_data     operand
//   in_amount   shift distance 0..WIDTH-1
//   in_mode     00 SLL, 01 SRL, 10 SRA, 11 ROR
//   in_tag      sideband, returned unchanged with the result
//   out_valid   result valid (last stage valid bit)
//   out_ready   consumer takes the result
//   out_data    shifted result (register output)
//   out_tag     tag of this result (register output)
//   out_sticky  OR of all bits shifted out (SHIFT_STICKY_EN only, else 0)
//
// Optional feature
//   SHIFT_STICKY_EN  when defined, out_sticky is the OR of every bit shifted
//                    past bit 0 (SRL/SRA) or past bit WIDTH-1 (SLL). It is
//                    accumulated level by level and pipelined with the data.
//                    It is always 0 for ROR and for amount 0. When the macro
//                    is undefined, the port is tied to 0 and no sticky
//                    storage exists.
// ---------------------------------------------------------------------------
module shift_pipe #(
   parameter int WIDTH      = 32,
   parameter int PIPE_EVERY = 1,
   parameter int TAG_W      = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [$clog2(WIDTH)-1:0] in_amount,
   input  logic [1:0]               in_mode,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_sticky
);

   localparam int SHW = $clog2(WIDTH);
   localparam int L   = (SHW + PIPE_EVERY - 1) / PIPE_EVERY;

   // Everything one operation carries from stage to stage.
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SHW-1:0]   amount;
      logic [1:0]       mode;
      logic             sign;
      logic [TAG_W-1:0] tag;
`ifdef SHIFT_STICKY_EN
      logic             sticky;
`endif
   } op_t;

   op_t  stage_q    [L];
   logic stage_v    [L];
   op_t  stage_in   [L];
   op_t  stage_next [L];
   logic stage_vin  [L];
   logic stage_load [L];

   // One mux level of fixed distance 2^(SHW-1-lvl). The caller applies it
   // only when the matching amount bit is set. SRA fills from the sign bit
   // of the original operand, not from the current top bit. A rotate loses
   // no bits, so it leaves the sticky flag unchanged.
   function automatic op_t shift_level(input op_t o, input int lvl);
      op_t              r;
      int               s;
      logic [WIDTH-1:0] top_mask;
`ifdef SHIFT_STICKY_EN
      logic [WIDTH-1:0] low_mask;
`endif
      r        = o;
      s        = 1 << (SHW - 1 - lvl);
      top_mask = ~({WIDTH{1'b1}} >> s);
`ifdef SHIFT_STICKY_EN
      low_mask = ~({WIDTH{1'b1}} << s);
`endif
      case (o.mode)
         2'b00: begin
`ifdef SHIFT_STICKY_EN
            r.sticky = o.sticky | (|(o.data & top_mask));
`endif
            r.data = o.data << s;
         end
         2'b01: begin
`ifdef SHIFT_STICKY_EN
            r.sticky = o.sticky | (|(o.data & low_mask));
`endif
            r.data = o.data >> s;
         end
         2'b10: begin
`ifdef SHIFT_STICKY_EN
            r.sticky = o.sticky | (|(o.data & low_mask));
`endif
            r.data = (o.data >> s) | (o.sign ? top_mask : '0);
         end
         default: begin
            r.data = (o.data >> s) | (o.data << (WIDTH - s));
         end
      endcase
      return r;
   endfunction

   // Build the input of every stage. Stage 0 is fed from the port. The sign
   // of the operand is captured here so that SRA fill survives later levels.
   // Each stage then applies its own slice of mux levels.
   always_comb begin
      op_t cur;
      cur = '0;
      for (int k = 0; k < L; k++) begin
         stage_in[k]   = '0;
         stage_next[k] = '0;
         stage_vin[k]  = 1'b0;
      end
      stage_in[0].data   = in_data;
      stage_in[0].amount = in_amount;
      stage_in[0].mode   = in_mode;
      stage_in[0].sign   = in_data[WIDTH-1];
      stage_in[0].tag    = in_tag;
      stage_vin[0]       = in_valid;
      for (int k = 1; k < L; k++) begin
         stage_in[k]  = stage_q[k-1];
         stage_vin[k] = stage_v[k-1];
      end
      for (int k = 0; k < L; k++) begin
         cur = stage_in[k];
         for (int lvl = k * PIPE_EVERY; lvl < (k + 1) * PIPE_EVERY && lvl < SHW; lvl++) begin
            if (cur.amount[SHW-1-lvl]) begin
               cur = shift_level(cur, lvl);
            end
         end
         stage_next[k] = cur;
      end
   end

   // Ready chain, walked from the output back to the input. A stage may load
   // when it is empty or when its contents move on in the same cycle. This
   // lets a full pipe accept and emit on the same edge without a bubble.
   always_comb begin
      logic downstream;
      downstream = out_ready;
      for (int k = L - 1; k >= 0; k--) begin
         stage_load[k] = !stage_v[k] || downstream;
         downstream    = stage_load[k];
      end
      in_ready = stage_load[0];
   end

   // Stage registers. The payload is only written when a valid operation
   // arrives. A bubble therefore never disturbs the data, and the input
   // fields are ignored while in_valid is low. A held stage keeps its value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < L; k++) begin
            stage_v[k] <= 1'b0;
            stage_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < L; k++) begin
            if (stage_load[k]) begin
               stage_v[k] <= stage_vin[k];
               if (stage_vin[k]) begin
                  stage_q[k] <= stage_next[k];
               end
            end
         end
      end
   end

   assign out_valid = stage_v[L-1];
   assign out_data  = stage_q[L-1].data;
   assign out_tag   = stage_q[L-1].tag;
`ifdef SHIFT_STICKY_EN
   assign out_sticky = stage_q[L-1].sticky;
`else
   assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_shift_pipe
//
// Self-checking bench for shift_pipe (WIDTH=32, PIPE_EVERY=1, TAG_W=4).
// A monitor runs on the falling edge. It records each accepted operation
// in a scoreboard queue. The expected value comes from a plain-arithmetic
// shift model. Every presented result is compared with the queue head.
// ---------------------------------------------------------------------------
module tb_shift_pipe;

   localparam int W  = 32;
   localparam int PE = 1;
   localparam int TW = 4;
   localparam int SW = $clog2(W);
   localparam int L  = (SW + PE - 1) / PE;

`ifdef SHIFT_STICKY_EN
   localparam bit STICKY_ON = 1'b1;
`else
   localparam bit STICKY_ON = 1'b0;
`endif

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data   = '0;
   logic [SW-1:0] in_amount = '0;
   logic [1:0]    in_mode   = '0;
   logic [TW-1:0] in_tag    = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_data;
   logic [TW-1:0] out_tag;
   logic          out_sticky;

   int checks     = 0;
   int failures   = 0;
   int cyc        = 0;
   int ready_mode = 0;
   bit strict_lat = 1'b0;

   typedef struct {
      logic [W-1:0]  data;
      logic [TW-1:0] tag;
      logic          sticky;
      int            acc;
   } exp_t;

   exp_t sb[$];

   shift_pipe #(.WIDTH(W), .PIPE_EVERY(PE), .TAG_W(TW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_amount  (in_amount),
      .in_mode    (in_mode),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_tag    (out_tag),
      .out_sticky (out_sticky)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer side: always ready, random, or fully stalled
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // Reference shift computed directly from the mode definitions
   function automatic logic [W-1:0] ref_data(input logic [W-1:0] d, input int a, input logic [1:0] m);
      logic signed [W-1:0] sd;
      sd = d;
      case (m)
         2'b00:   ref_data = d << a;
         2'b01:   ref_data = d >> a;
         2'b10:   ref_data = W'(sd >>> a);
         default: ref_data = (a == 0) ? d : ((d >> a) | (d << (W - a)));
      endcase
   endfunction

   // Sticky: place the operand in a double-width word and look at what falls off
   function automatic logic ref_sticky(input logic [W-1:0] d, input int a, input logic [1:0] m);
      logic [2*W-1:0] wide;
      ref_sticky = 1'b0;
      case (m)
         2'b00: begin
            wide       = {{W{1'b0}}, d} << a;
            ref_sticky = |wide[2*W-1:W];
         end
         2'b01, 2'b10: begin
            wide       = {d, {W{1'b0}}} >> a;
            ref_sticky = |wide[W-1:0];
         end
         default: ref_sticky = 1'b0;
      endcase
      ref_sticky = ref_sticky & STICKY_ON;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, actual, expected, cyc);
      end
   endtask

   // Monitor and scoreboard, sampled mid-cycle while all signals are settled
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         checkOutput("in_ready", 64'(in_ready), 64'(!(sb.size() == L && !out_ready)));
         if (out_valid) begin
            if (sb.size() == 0) begin
               checkOutput("stale_out_valid", 64'(out_valid), 64'(0));
            end else begin
               checkOutput("out_data", 64'(out_data), 64'(sb[0].data));
               checkOutput("out_tag", 64'(out_tag), 64'(sb[0].tag));
               checkOutput("out_sticky", 64'(out_sticky), 64'(sb[0].sticky));
               if (out_ready) begin
                  if (strict_lat) checkOutput("latency", 64'(cyc - sb[0].acc), 64'(L));
                  void'(sb.pop_front());
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_t e;
            e.data   = ref_data(in_data, int'(in_amount), in_mode);
            e.tag    = in_tag;
            e.sticky = ref_sticky(in_data, int'(in_amount), in_mode);
            e.acc    = cyc;
            sb.push_back(e);
         end
      end
   end

   task automatic applyStimulus(input logic [W-1:0] d, input logic [SW-1:0] a, input logic [1:0] m, input logic [TW-1:0] t);
      int n;
      bit done;
      n         = 0;
      done      = 1'b0;
      in_valid  = 1'b1;
      in_data   = d;
      in_amount = a;
      in_mode   = m;
      in_tag    = t;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1'b1;
         end else begin
            n++;
            if (n > 1000) begin
               checkOutput("accept_timeout", 64'(in_ready), 64'(1));
               done = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic goIdle();
      in_valid  = 1'b0;
      in_data   = W'($urandom);
      in_amount = SW'($urandom);
      in_mode   = 2'($urandom);
      in_tag    = TW'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'(0));
      repeat (L + 2) @(posedge clk);
      #1;
   endtask

   // Single operation into an empty pipe with out_ready held high.
   // out_valid must stay low until the L-th edge counted from the accept edge.
   task automatic checkDirected(input string name, input logic [W-1:0] d, input logic [SW-1:0] a,
                                input logic [1:0] m, input logic [TW-1:0] t,
                                input logic [W-1:0] exp_d, input logic exp_s);
      applyStimulus(d, a, m, t);
      goIdle();
      for (int i = 1; i < L; i++) begin
         checkOutput({name, "_early"}, 64'(out_valid), 64'(0));
         @(posedge clk);
         #1;
      end
      checkOutput({name, "_valid"}, 64'(out_valid), 64'(1));
      checkOutput(name, 64'(out_data), 64'(exp_d));
      checkOutput({name, "_tag"}, 64'(out_tag), 64'(t));
      checkOutput({name, "_sticky"}, 64'(out_sticky), 64'(exp_s & STICKY_ON));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #600000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int start;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("rst_out_data", 64'(out_data), 64'(0));
      checkOutput("rst_out_tag", 64'(out_tag), 64'(0));
      checkOutput("rst_out_sticky", 64'(out_sticky), 64'(0));
      checkOutput("rst_in_ready", 64'(in_ready), 64'(1));

      // Directed corner cases with exact latency
      strict_lat = 1'b1;
      checkDirected("sra_8000_by4", 32'h8000_0000, 5'd4, 2'b10, 4'h1, 32'hF800_0000, 1'b0);
      checkDirected("srl_8000_by4", 32'h8000_0000, 5'd4, 2'b01, 4'h2, 32'h0800_0000, 1'b0);
      checkDirected("ror_1_by1", 32'h0000_0001, 5'd1, 2'b11, 4'h3, 32'h8000_0000, 1'b0);
      checkDirected("sll_ffff_by31", 32'hFFFF_FFFF, 5'd31, 2'b00, 4'h4, 32'h8000_0000, 1'b1);
      checkDirected("sll_by0", 32'hA5C3_0F96, 5'd0, 2'b00, 4'h5, 32'hA5C3_0F96, 1'b0);
      checkDirected("srl_by0", 32'hA5C3_0F96, 5'd0, 2'b01, 4'h6, 32'hA5C3_0F96, 1'b0);
      checkDirected("sra_by0", 32'hA5C3_0F96, 5'd0, 2'b10, 4'h7, 32'hA5C3_0F96, 1'b0);
      checkDirected("ror_by0", 32'hA5C3_0F96, 5'd0, 2'b11, 4'h8, 32'hA5C3_0F96, 1'b0);
      checkDirected("srl_13_by4", 32'h0000_0013, 5'd4, 2'b01, 4'h9, 32'h0000_0001, 1'b1);
      checkDirected("srl_10_by4", 32'h0000_0010, 5'd4, 2'b01, 4'hA, 32'h0000_0001, 1'b0);
      checkDirected("ror_13_by4", 32'h0000_0013, 5'd4, 2'b11, 4'hB, 32'h3000_0001, 1'b0);
      strict_lat = 1'b0;

      // Eight back-to-back ops, tags 0..7, random back-pressure
      ready_mode = 1;
      for (int t = 0; t < 8; t++) begin
         applyStimulus(W'($urandom), SW'($urandom), 2'($urandom), TW'(t));
      end
      goIdle();
      drain();

      // Reset while three operations are held in the pipe
      ready_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(32'hDEAD_BEEF, 5'd0, 2'b00, 4'hC);
      applyStimulus(32'h1234_5678, 5'd0, 2'b01, 4'hD);
      applyStimulus(32'hCAFE_F00D, 5'd0, 2'b11, 4'hE);
      goIdle();
      repeat (L + 2) @(posedge clk);
      #1;
      checkOutput("held_out_valid", 64'(out_valid), 64'(1));
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("midrst_out_data", 64'(out_data), 64'(0));
      checkOutput("midrst_out_tag", 64'(out_tag), 64'(0));
      checkOutput("midrst_out_sticky", 64'(out_sticky), 64'(0));
      rst = 1'b0;
      ready_mode = 0;
      repeat (L + 4) @(posedge clk);
      #1;
      checkOutput("postrst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("postrst_in_ready", 64'(in_ready), 64'(1));

      // Long random run, all modes and amounts, gaps and back-pressure
      ready_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            goIdle();
            @(posedge clk);
            #1;
         end
         applyStimulus(W'($urandom), SW'($urandom), 2'($urandom), TW'($urandom));
      end
      goIdle();
      drain();

      // Full throughput with out_ready held high: one accept per cycle, fixed latency
      ready_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      strict_lat = 1'b1;
      start = cyc;
      for (int i = 0; i < 200; i++) begin
         applyStimulus(W'($urandom), SW'($urandom), 2'($urandom), TW'($urandom));
      end
      checkOutput("throughput_cycles", 64'(cyc - start), 64'(200));
      goIdle();
      drain();
      strict_lat = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
